// File: rtl/dvid_timing_pkg.sv
// rtl/dvid_timing_pkg.sv - shared state type, 640x480@60 timing defaults and helpers for the DVI-D timing block
package dvid_timing_pkg;

  typedef enum logic [1:0] {S_RST, S_LOCK, S_ALIGN, S_RUN} state_t;

  // Raw timing flags carried down the alignment delay line
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } tbits_t;

  localparam int PIX_W = 10;
  localparam int RGB_W = 24;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvid_timing_ctrl_if.sv
// rtl/dvid_timing_ctrl_if.sv - pixel fetch bus between the timing block and the frame-buffer source
interface dvid_timing_ctrl_if;
  logic                              pix_req;
  logic [dvid_timing_pkg::PIX_W-1:0] pix_x;
  logic [dvid_timing_pkg::PIX_W-1:0] pix_y;
  logic [dvid_timing_pkg::RGB_W-1:0] pix_data;

  modport master (output pix_req, pix_x, pix_y, input pix_data);
  modport slave  (input pix_req, pix_x, pix_y, output pix_data);
endinterface

// File: rtl/dvid_delay_line.sv
// rtl/dvid_delay_line.sv - DEPTH-stage register pipe with synchronous clear
module dvid_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_pixel,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk_pixel) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dvid_timing_ctrl.sv
// rtl/dvid_timing_ctrl.sv - DVI-D startup sequencing, video timing, pixel fetch and RGB/sync realignment
module dvid_timing_ctrl
  import dvid_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_LAT  = 2,
  parameter int   RST_HOLD = 16
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               pll_locked,
  dvid_timing_ctrl_if.master pix,
  output logic [7:0]         red_p,
  output logic [7:0]         green_p,
  output logic [7:0]         blue_p,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               serdes_reset,
  output logic               frame_start,
  output logic               running
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(RST_HOLD + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt;
  logic          lock_seen;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last, v_last;
  logic          flush;
  tbits_t        raw, s0, dly;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_ff @(posedge clk_pixel) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!pll_locked) begin
      state_nxt = S_RST;
    end else begin
      unique case (state)
        S_RST:   if (hold_cnt == HOLD_LAST) state_nxt = S_LOCK;
        S_LOCK:  if (lock_seen) state_nxt = S_ALIGN;
        S_ALIGN: if (h_last && v_last) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
      endcase
    end
  end

  always_comb begin
    serdes_reset = (state == S_RST) || (state == S_LOCK);
    running      = (state == S_RUN);
  end

  // Lock loss inside S_RST also restarts the hold window
  always_ff @(posedge clk_pixel) begin
    if (reset || state != S_RST || !pll_locked) hold_cnt <= '0;
    else if (hold_cnt != HOLD_LAST)             hold_cnt <= hold_cnt + CW'(1);
    lock_seen <= !reset && (state == S_LOCK) && pll_locked;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset || !(state == S_ALIGN || state == S_RUN)) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : h + HW'(1);
      if (h_last) v <= v_last ? '0 : v + VW'(1);
    end
  end

  always_comb begin
    raw.active = (h < H_ACT) && (v < V_ACT);
    raw.hs     = (h >= HS_BEG) && (h < HS_END);
    raw.vs     = (v >= VS_BEG) && (v < VS_END);
    raw.first  = (h == '0) && (v == '0);
  end

  // Gating on the next state lets lock loss or reset idle the whole stream on the very next cycle
  assign flush = reset || (state_nxt != S_RUN);

  always_ff @(posedge clk_pixel) begin
    if (flush) begin
      pix.pix_req <= 1'b0;
      s0          <= '0;
    end else begin
      pix.pix_req <= raw.active;
      s0          <= raw;
    end
    if (reset) begin
      pix.pix_x <= '0;
      pix.pix_y <= '0;
    end else if (!flush && raw.active) begin
      pix.pix_x <= PIX_W'(h);
      pix.pix_y <= PIX_W'(v);
    end
  end

  dvid_delay_line #(
    .WIDTH ($bits(tbits_t)),
    .DEPTH (PIX_LAT)
  ) u_align (
    .clk_pixel (clk_pixel),
    .clr       (flush),
    .din       (s0),
    .dout      (dly)
  );

  always_ff @(posedge clk_pixel) begin
    if (flush) begin
      {red_p, green_p, blue_p} <= '0;
      blank       <= 1'b1;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      {red_p, green_p, blue_p} <= dly.active ? pix.pix_data : '0;
      blank       <= ~dly.active;
      hsync       <= dly.hs ? HS_POL : ~HS_POL;
      vsync       <= dly.vs ? VS_POL : ~VS_POL;
      frame_start <= dly.first;
    end
  end

endmodule

// File: tb/tb_dvid_timing_ctrl.sv
// tb/tb_dvid_timing_ctrl.sv - self-checking bench for dvid_timing_ctrl in a 7x5 small timing mode
module tb_dvid_timing_ctrl;

  localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 1, H_BP = 1;
  localparam int V_ACTIVE = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_LAT  = 3;
  localparam int RST_HOLD = 16;

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
    logic        first;
  } exp_t;

  typedef struct {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
  } req_t;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic [7:0] red_p, green_p, blue_p;
  logic       blank, hsync, vsync, serdes_reset, frame_start, running;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   sb_en  = 1'b0;
  int   exp_x, exp_y;
  exp_t exp_q[$];
  req_t hist [PIX_LAT+1];

  dvid_timing_ctrl_if pif ();

  dvid_timing_ctrl #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (1'b0),     .VS_POL (1'b0),
    .PIX_LAT  (PIX_LAT),  .RST_HOLD (RST_HOLD)
  ) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .pix          (pif.master),
    .red_p        (red_p),
    .green_p      (green_p),
    .blue_p       (blue_p),
    .blank        (blank),
    .hsync        (hsync),
    .vsync        (vsync),
    .serdes_reset (serdes_reset),
    .frame_start  (frame_start),
    .running      (running)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [23:0] model_rgb(input logic [9:0] x, input logic [9:0] y);
    return {x[7:0], y[7:0], 8'hA5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_serdes_reset"}, serdes_reset, 1);
    chk({tag, "_blank"}, blank, 1);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_rgb"}, {red_p, green_p, blue_p}, 0);
    chk({tag, "_pix_req"}, pif.pix_req, 0);
    chk({tag, "_pix_x"}, pif.pix_x, 0);
    chk({tag, "_pix_y"}, pif.pix_y, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_running"}, running, 0);
  endtask

  // Scoreboard plus frame-buffer model; runs on the falling edge, away from DUT updates
  always @(negedge clk_pixel) begin
    exp_t e;
    cyc++;
    if (sb_en) begin
      if (pif.pix_req === 1'b1) begin
        chk("pix_x", pif.pix_x, exp_x);
        chk("pix_y", pif.pix_y, exp_y);
        e.cyc   = cyc + PIX_LAT + 1;
        e.rgb   = model_rgb(pif.pix_x, pif.pix_y);
        e.first = (pif.pix_x == 10'd0) && (pif.pix_y == 10'd0);
        exp_q.push_back(e);
        if (exp_x == H_ACTIVE - 1) begin
          exp_x = 0;
          exp_y = (exp_y == V_ACTIVE - 1) ? 0 : exp_y + 1;
        end else begin
          exp_x = exp_x + 1;
        end
      end
      if (blank === 1'b0) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_latency", cyc, e.cyc);
          chk("out_rgb", {red_p, green_p, blue_p}, e.rgb);
          chk("frame_start", frame_start, e.first);
        end
      end else begin
        chk("blank_rgb_zero", {red_p, green_p, blue_p}, 0);
        chk("blank_no_frame_start", frame_start, 0);
      end
    end
    for (int i = PIX_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = '{req: pif.pix_req, x: pif.pix_x, y: pif.pix_y};
    pif.pix_data = (hist[PIX_LAT].req === 1'b1) ? model_rgb(hist[PIX_LAT].x, hist[PIX_LAT].y)
                                                : 24'($urandom);
  end

  task automatic start_scoreboard();
    exp_q.delete();
    exp_x = 0;
    exp_y = 0;
    sb_en = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    reset      = 1'b1;
    pll_locked = 1'b1;
    for (int i = 0; i < PIX_LAT + 1; i++) hist[i] = '{req: 1'b0, x: '0, y: '0};
    pif.pix_data = '0;
    repeat (3) tick();
    chk_reset_values("init");

    // Startup: serdes_reset spans the hold window plus two lock cycles, then one aligning frame
    reset = 1'b0;
    n = 0;
    while (serdes_reset === 1'b1 && n < 100) begin n++; tick(); end
    chk("serdes_reset_cycles", n, RST_HOLD + 2);
    chk("align_not_running", running, 0);
    n = 0;
    while (running !== 1'b1 && n < 1000) begin n++; tick(); end
    chk("align_frame_cycles", n, H_TOTAL * V_TOTAL);
    start_scoreboard();

    // Line and frame timing on the realigned outputs
    n = 0;
    while (blank !== 1'b0 && n < 200) begin n++; tick(); end
    n = 0;
    while (blank === 1'b0 && n < 200) begin n++; tick(); end
    chk("active_len", n, H_ACTIVE);
    n = 0;
    while (hsync === 1'b1 && n < 200) begin n++; tick(); end
    chk("hsync_after_blank", n, H_FP);
    n = 0;
    while (hsync === 1'b0 && n < 200) begin n++; tick(); end
    chk("hsync_width", n, H_SYNC);
    while (hsync !== 1'b0 && n < 400) begin n++; tick(); end
    n = 0;
    while (hsync === 1'b0 && n < 200) begin n++; tick(); end
    while (hsync !== 1'b0 && n < 200) begin n++; tick(); end
    chk("line_period", n, H_TOTAL);
    n = 0;
    while (vsync !== 1'b0 && n < 200) begin n++; tick(); end
    n = 0;
    while (vsync === 1'b0 && n < 200) begin n++; tick(); end
    chk("vsync_width", n, V_SYNC * H_TOTAL);
    n = 0;
    while (blank === 1'b1 && n < 200) begin n++; tick(); end
    chk("vsync_to_active", n, V_BP * H_TOTAL);
    n = 0;
    while (frame_start !== 1'b1 && n < 200) begin n++; tick(); end
    n = 0;
    do begin n++; tick(); end while (frame_start !== 1'b1 && n < 200);
    chk("frame_period", n, H_TOTAL * V_TOTAL);

    // Lock loss mid-line at pixel (2,1)
    n = 0;
    while (!(pif.pix_req === 1'b1 && pif.pix_x == 10'd2 && pif.pix_y == 10'd1) && n < 200) begin
      n++; tick();
    end
    chk("found_mid_line", n < 200, 1);
    sb_en      = 1'b0;
    pll_locked = 1'b0;
    tick();
    chk("lock_loss_running", running, 0);
    chk("lock_loss_serdes_reset", serdes_reset, 1);
    chk("lock_loss_pix_req", pif.pix_req, 0);
    repeat (PIX_LAT + 1) tick();
    chk("lock_loss_blank", blank, 1);
    chk("lock_loss_hsync", hsync, 1);
    chk("lock_loss_vsync", vsync, 1);
    chk("lock_loss_rgb", {red_p, green_p, blue_p}, 0);
    pll_locked = 1'b1;
    bad = 0;
    n = 0;
    while (running !== 1'b1 && n < 500) begin
      if (pif.pix_req !== 1'b0 || blank !== 1'b1) bad++;
      n++; tick();
    end
    chk("relock_reached_run", running, 1);
    chk("no_req_before_run", bad, 0);
    start_scoreboard();
    repeat (2 * H_TOTAL * V_TOTAL + 5) tick();
    chk("sb_drained_in_flight", exp_q.size() <= PIX_LAT + 1, 1);

    // Reset while running wins over a steady pll_locked
    sb_en = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_values("run_reset");
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
